control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Fetch/execute sequencer that sits directly upstream of the register file and generates all its select/assert/load/increment lines, plus memory-read and ALU-assert strobes.
- Fetches one opcode byte per instruction from memory at the PC (address register 0) over the main bus, latches it in an internal instruction register (IR), and sequences the register transfer it encodes.
- Supports single-byte MOV, ALU and NOP/HALT, and two-byte LDI (load immediate), with a MEM_READY wait handshake.

Parameters:
- DELAY_RISE, 0, output rise delay applied to all control outputs
- DELAY_FALL, 0, output fall delay applied to all control outputs
- PC_SEL, 3'd0, address-register index used as program counter
- ACC_SEL, 3'd0, general-purpose register index receiving ALU results

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_bar  in  1  asynchronous active-low reset
- MAIN_BUS  in  8  main data bus (memory drives it when MEM_READ_bar is low)
- MEM_READY  in  1  memory data valid this cycle
- MEM_READ_bar  out  1  memory drives MAIN_BUS from the address bus
- ALU_ASSERT_bar  out  1  ALU drives its result onto MAIN_BUS
- ADDR_ASSERT_bar, ADDR_LOAD_bar  out  1  address-register master controls
- ADDR_INC  out  1  address-register increment enable
- ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL  out  3  address-register selects
- MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar  out  1  8-bit master controls
- MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL  out  3  8-bit selects
- HALTED  out  1  high in HALT state

Behaviour:
- Reset:
  - CLK is the single clock. RST_bar is asynchronous and active-low.
  - While RST_bar is low: state=FETCH, IR=8'h00.
  - All _bar outputs are forced high, ADDR_INC=0, HALTED=0, and all selects are 3'd0, regardless of state.
  - Reset asserted mid-instruction aborts it immediately; no partial load completes.
- ADDR_LOAD_bar is held high always (reserved for jumps).
- Opcode classes (IR[7:6]):
  - 00 = MOV d=IR[5:3], s=IR[2:0]
  - 01 = LDI d=IR[5:3]
  - 10 = ALU a=IR[5:3], b=IR[2:0]
  - 11 = SYS: 8'hC0 is HALT; any other value is NOP
- The 3-bit fields pass through unchanged. Indices 4-7 address no register; the sequencer does not trap them.
- FETCH:
  - Drives ADDR_ASSERT_bar=0, ADDR_ASSERT_SEL=PC_SEL, MEM_READ_bar=0.
  - When MEM_READY=1: ADDR_INC=1 with ADDR_INC_SEL=PC_SEL. On the edge, IR<=MAIN_BUS and next state is EXEC.
  - When MEM_READY=0: ADDR_INC=0 and the state holds.
- EXEC, MOV: MAIN_ASSERT_bar=0 sel=s; MAIN_LOAD_bar=0 sel=d; next FETCH. d==s is legal.
- EXEC, ALU: LHS_ASSERT_bar=0 sel=a; RHS_ASSERT_bar=0 sel=b; ALU_ASSERT_bar=0; MAIN_LOAD_bar=0 sel=ACC_SEL; next FETCH.
- EXEC, LDI:
  - Drives the FETCH address/read lines.
  - MAIN_LOAD_bar=0 sel=d and ADDR_INC=1 sel=PC_SEL, both only while MEM_READY=1.
  - Stays in EXEC until MEM_READY=1, then goes to FETCH. PC therefore advances by 2 in total.
- EXEC, NOP: no strobes; next FETCH.
- EXEC, HALT: no strobes; next HALT.
- HALT: no strobes, HALTED=1; exits only via reset.
- Control outputs are combinational from state, IR and MEM_READY (Moore, except for MEM_READY gating).
- At most one source drives MAIN_BUS in any cycle.
- MEM_READY is ignored outside FETCH and LDI-EXEC.
- Latency: MOV/ALU/NOP take 2 cycles and LDI takes 2 cycles, each plus wait cycles.

Decomposition:
- Shared package `cpu_ctrl_pkg`: state encoding (FETCH=2'd0, EXEC=2'd1, HALT=2'd2), opcode class constants, HALT opcode 8'hC0, PC_SEL/ACC_SEL defaults.
- One sub-module `instr_decode`: purely combinational; maps state, IR and MEM_READY to all control outputs and next state.
- The top module holds the state and IR registers and the reset gating.

Test Plan:
- Reset: hold RST_bar low for 3 cycles with MAIN_BUS=8'hFF -> all _bar outputs =1, ADDR_INC=0. First cycle after release shows FETCH strobes with ADDR_ASSERT_SEL=0.
- MOV 8'h0B (d=1, s=3), MEM_READY=1 -> FETCH cycle has ADDR_INC=1. Next cycle MAIN_ASSERT_SEL=3, MAIN_LOAD_SEL=1, both bars low. Third cycle returns to FETCH.
- LDI 8'h50 (d=2) then 8'hA5 with MEM_READY low for 2 cycles in EXEC -> EXEC holds 3 cycles. MAIN_LOAD_bar=0 and ADDR_INC=1 only in the final cycle, with MAIN_LOAD_SEL=2. ADDR_INC is pulsed exactly twice in total.
- ALU 8'h8A (a=1, b=2) -> LHS_ASSERT_SEL=1, RHS_ASSERT_SEL=2, ALU_ASSERT_bar=0, MAIN_LOAD_SEL=0, MEM_READ_bar=1.
- HALT 8'hC0 -> HALTED=1 after EXEC and stays high for 10 cycles with no strobes despite MEM_READY toggling. Pulsing RST_bar returns to FETCH with HALTED=0.
- Reset mid-LDI wait -> outputs deassert asynchronously and IR reads 8'h00. On restart, FETCH begins with no stray MAIN_LOAD_bar.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the fetch/execute control sequencer: state
// encoding, opcode classes, the bundled control word and its idle value.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seq_state_t;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [7:0] HALT_OPCODE = 8'hC0;

    localparam logic [2:0] DEFAULT_PC_SEL  = 3'd0;
    localparam logic [2:0] DEFAULT_ACC_SEL = 3'd0;

    // Every strobe and select the sequencer drives, kept together so the
    // idle value and the reset gating are expressed once.
    typedef struct packed {
        logic       mem_read_bar;
        logic       alu_assert_bar;
        logic       addr_assert_bar;
        logic       addr_load_bar;
        logic       addr_inc;
        logic [2:0] addr_assert_sel;
        logic [2:0] addr_load_sel;
        logic [2:0] addr_inc_sel;
        logic       main_assert_bar;
        logic       main_load_bar;
        logic       lhs_assert_bar;
        logic       rhs_assert_bar;
        logic [2:0] main_assert_sel;
        logic [2:0] main_load_sel;
        logic [2:0] lhs_assert_sel;
        logic [2:0] rhs_assert_sel;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mem_read_bar:    1'b1,
        alu_assert_bar:  1'b1,
        addr_assert_bar: 1'b1,
        addr_load_bar:   1'b1,
        addr_inc:        1'b0,
        addr_assert_sel: 3'd0,
        addr_load_sel:   3'd0,
        addr_inc_sel:    3'd0,
        main_assert_bar: 1'b1,
        main_load_bar:   1'b1,
        lhs_assert_bar:  1'b1,
        rhs_assert_bar:  1'b1,
        main_assert_sel: 3'd0,
        main_load_sel:   3'd0,
        lhs_assert_sel:  3'd0,
        rhs_assert_sel:  3'd0,
        halted:          1'b0
    };

    function automatic logic [1:0] op_class(input logic [7:0] ir);
        return ir[7:6];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus and register-file control lines between the sequencer (master) and
// the datapath/memory it steers (slave).
interface control_sequencer_if;

    logic [7:0] MAIN_BUS;
    logic       MEM_READY;
    logic       MEM_READ_bar;
    logic       ALU_ASSERT_bar;
    logic       ADDR_ASSERT_bar;
    logic       ADDR_LOAD_bar;
    logic       ADDR_INC;
    logic [2:0] ADDR_ASSERT_SEL;
    logic [2:0] ADDR_LOAD_SEL;
    logic [2:0] ADDR_INC_SEL;
    logic       MAIN_ASSERT_bar;
    logic       MAIN_LOAD_bar;
    logic       LHS_ASSERT_bar;
    logic       RHS_ASSERT_bar;
    logic [2:0] MAIN_ASSERT_SEL;
    logic [2:0] MAIN_LOAD_SEL;
    logic [2:0] LHS_ASSERT_SEL;
    logic [2:0] RHS_ASSERT_SEL;
    logic       HALTED;

    modport master (
        input  MAIN_BUS, MEM_READY,
        output MEM_READ_bar, ALU_ASSERT_bar,
        output ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC,
        output ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL,
        output MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar,
        output MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL,
        output HALTED
    );

    modport slave (
        output MAIN_BUS, MEM_READY,
        input  MEM_READ_bar, ALU_ASSERT_bar,
        input  ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC,
        input  ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL,
        input  MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar,
        input  MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL,
        input  HALTED
    );

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational decoder: turns the current state, the latched opcode and
// MEM_READY into the full control word and the next sequencer state.
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_SEL  = DEFAULT_PC_SEL,
    parameter logic [2:0] ACC_SEL = DEFAULT_ACC_SEL
) (
    input  seq_state_t state,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output seq_state_t next_state,
    output logic       ir_load
);

    // Start from the all-idle control word and raise only the strobes the
    // current step needs, so at most one source ever drives MAIN_BUS.
    always_comb begin
        ctrl       = CTRL_IDLE;
        next_state = state;
        ir_load    = 1'b0;
        case (state)
            FETCH: begin
                ctrl.addr_assert_bar = 1'b0;
                ctrl.addr_assert_sel = PC_SEL;
                ctrl.mem_read_bar    = 1'b0;
                if (mem_ready) begin
                    ctrl.addr_inc     = 1'b1;
                    ctrl.addr_inc_sel = PC_SEL;
                    ir_load           = 1'b1;
                    next_state        = EXEC;
                end
            end
            EXEC: begin
                case (op_class(ir))
                    OP_MOV: begin
                        ctrl.main_assert_bar = 1'b0;
                        ctrl.main_assert_sel = ir[2:0];
                        ctrl.main_load_bar   = 1'b0;
                        ctrl.main_load_sel   = ir[5:3];
                        next_state           = FETCH;
                    end
                    OP_ALU: begin
                        ctrl.lhs_assert_bar = 1'b0;
                        ctrl.lhs_assert_sel = ir[5:3];
                        ctrl.rhs_assert_bar = 1'b0;
                        ctrl.rhs_assert_sel = ir[2:0];
                        ctrl.alu_assert_bar = 1'b0;
                        ctrl.main_load_bar  = 1'b0;
                        ctrl.main_load_sel  = ACC_SEL;
                        next_state          = FETCH;
                    end
                    OP_LDI: begin
                        ctrl.addr_assert_bar = 1'b0;
                        ctrl.addr_assert_sel = PC_SEL;
                        ctrl.mem_read_bar    = 1'b0;
                        if (mem_ready) begin
                            ctrl.main_load_bar = 1'b0;
                            ctrl.main_load_sel = ir[5:3];
                            ctrl.addr_inc      = 1'b1;
                            ctrl.addr_inc_sel  = PC_SEL;
                            next_state         = FETCH;
                        end
                    end
                    default: begin
                        next_state = (ir == HALT_OPCODE) ? HALT : FETCH;
                    end
                endcase
            end
            HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer top: holds the state and instruction registers
// and forces every control line idle while reset is asserted.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         DELAY_RISE = 0,
    parameter int         DELAY_FALL = 0,
    parameter logic [2:0] PC_SEL     = DEFAULT_PC_SEL,
    parameter logic [2:0] ACC_SEL    = DEFAULT_ACC_SEL
) (
    input  logic                 CLK,
    input  logic                 RST_bar,
    control_sequencer_if.master  bus
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [7:0] ir_q;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;
    logic       ir_load;

    // Output delays describe board-level timing only; the synthesized
    // control path is zero-delay, so nonzero values add no logic here.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_board_delay
    end

    instr_decode #(
        .PC_SEL  (PC_SEL),
        .ACC_SEL (ACC_SEL)
    ) u_decode (
        .state      (state_q),
        .ir         (ir_q),
        .mem_ready  (bus.MEM_READY),
        .ctrl       (dec_ctrl),
        .next_state (state_d),
        .ir_load    (ir_load)
    );

    // State and opcode registers; reset aborts any instruction in flight.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q <= FETCH;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= bus.MAIN_BUS;
            end
        end
    end

    // Reset overrides the decoder combinationally so no strobe leaks out
    // while RST_bar is low, even though the state already reads FETCH.
    assign ctrl = RST_bar ? dec_ctrl : CTRL_IDLE;

    assign bus.MEM_READ_bar    = ctrl.mem_read_bar;
    assign bus.ALU_ASSERT_bar  = ctrl.alu_assert_bar;
    assign bus.ADDR_ASSERT_bar = ctrl.addr_assert_bar;
    assign bus.ADDR_LOAD_bar   = ctrl.addr_load_bar;
    assign bus.ADDR_INC        = ctrl.addr_inc;
    assign bus.ADDR_ASSERT_SEL = ctrl.addr_assert_sel;
    assign bus.ADDR_LOAD_SEL   = ctrl.addr_load_sel;
    assign bus.ADDR_INC_SEL    = ctrl.addr_inc_sel;
    assign bus.MAIN_ASSERT_bar = ctrl.main_assert_bar;
    assign bus.MAIN_LOAD_bar   = ctrl.main_load_bar;
    assign bus.LHS_ASSERT_bar  = ctrl.lhs_assert_bar;
    assign bus.RHS_ASSERT_bar  = ctrl.rhs_assert_bar;
    assign bus.MAIN_ASSERT_SEL = ctrl.main_assert_sel;
    assign bus.MAIN_LOAD_SEL   = ctrl.main_load_sel;
    assign bus.LHS_ASSERT_SEL  = ctrl.lhs_assert_sel;
    assign bus.RHS_ASSERT_SEL  = ctrl.rhs_assert_sel;
    assign bus.HALTED          = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a table of per-cycle vectors
// plus hand-written reset sequences, checked through an expectation queue.
module tb_control_sequencer;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        ready;
        logic [7:0]  bus_val;
        logic [30:0] exp;
    } vec_t;

    logic CLK;
    logic RST_bar;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .CLK     (CLK),
        .RST_bar (RST_bar),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;

    logic [30:0] exp_q[$];
    string       name_q[$];
    vec_t        vecs[$];

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [30:0] mk(
        input logic mrb, input logic aab, input logic adab, input logic adlb,
        input logic inc, input logic [2:0] asel, input logic [2:0] lsel,
        input logic [2:0] isel, input logic mab, input logic mlb,
        input logic lhb, input logic rhb, input logic [2:0] masel,
        input logic [2:0] mlsel, input logic [2:0] lhsel,
        input logic [2:0] rhsel, input logic h);
        return {mrb, aab, adab, adlb, inc, asel, lsel, isel, mab, mlb,
                lhb, rhb, masel, mlsel, lhsel, rhsel, h};
    endfunction

    function automatic logic [30:0] e_idle(input logic h);
        return mk(1, 1, 1, 1, 0, 3'd0, 3'd0, 3'd0, 1, 1, 1, 1,
                  3'd0, 3'd0, 3'd0, 3'd0, h);
    endfunction

    function automatic logic [30:0] e_fetch(input logic r);
        return mk(0, 1, 0, 1, r, 3'd0, 3'd0, 3'd0, 1, 1, 1, 1,
                  3'd0, 3'd0, 3'd0, 3'd0, 0);
    endfunction

    function automatic logic [30:0] e_mov(input logic [2:0] d, input logic [2:0] s);
        return mk(1, 1, 1, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 1,
                  s, d, 3'd0, 3'd0, 0);
    endfunction

    function automatic logic [30:0] e_alu(input logic [2:0] a, input logic [2:0] b);
        return mk(1, 0, 1, 1, 0, 3'd0, 3'd0, 3'd0, 1, 0, 0, 0,
                  3'd0, 3'd0, a, b, 0);
    endfunction

    function automatic logic [30:0] e_ldi(input logic [2:0] d, input logic r);
        return mk(0, 1, 0, 1, r, 3'd0, 3'd0, 3'd0, 1, ~r, 1, 1,
                  3'd0, r ? d : 3'd0, 3'd0, 3'd0, 0);
    endfunction

    function automatic logic [30:0] actual_word();
        return mk(bus_if.MEM_READ_bar, bus_if.ALU_ASSERT_bar,
                  bus_if.ADDR_ASSERT_bar, bus_if.ADDR_LOAD_bar, bus_if.ADDR_INC,
                  bus_if.ADDR_ASSERT_SEL, bus_if.ADDR_LOAD_SEL, bus_if.ADDR_INC_SEL,
                  bus_if.MAIN_ASSERT_bar, bus_if.MAIN_LOAD_bar,
                  bus_if.LHS_ASSERT_bar, bus_if.RHS_ASSERT_bar,
                  bus_if.MAIN_ASSERT_SEL, bus_if.MAIN_LOAD_SEL,
                  bus_if.LHS_ASSERT_SEL, bus_if.RHS_ASSERT_SEL, bus_if.HALTED);
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic checkOutput();
        logic [30:0] e;
        string       n;
        if (exp_q.size() == 0) begin
            compare("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, {1'b0, actual_word()}, {1'b0, e});
        end
    endtask

    // Drive one cycle's inputs at the falling edge, record what the outputs
    // must be, then sample shortly after (well before the rising edge).
    task automatic applyStimulus(input logic rst_n, input logic ready,
                                 input logic [7:0] bus_val, input logic [30:0] exp,
                                 input string name);
        @(negedge CLK);
        RST_bar          = rst_n;
        bus_if.MEM_READY = ready;
        bus_if.MAIN_BUS  = bus_val;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        checkOutput();
    endtask

    task automatic add_vec(input string n, input logic r, input logic m,
                           input logic [7:0] b, input logic [30:0] e);
        vec_t v;
        v.name = n; v.rst_n = r; v.ready = m; v.bus_val = b; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int inc_count;
        RST_bar          = 1'b0;
        bus_if.MEM_READY = 1'b0;
        bus_if.MAIN_BUS  = 8'hFF;

        // Main program: reset, MOV, LDI with wait, ALU, NOP, HALT.
        add_vec("reset_0",     0, 0, 8'hFF, e_idle(0));
        add_vec("reset_1",     0, 0, 8'hFF, e_idle(0));
        add_vec("reset_2",     0, 0, 8'hFF, e_idle(0));
        add_vec("fetch_wait",  1, 0, 8'hFF, e_fetch(0));
        add_vec("fetch_mov",   1, 1, 8'h0B, e_fetch(1));
        add_vec("exec_mov",    1, 0, 8'hFF, e_mov(3'd1, 3'd3));
        add_vec("fetch_ldi",   1, 1, 8'h50, e_fetch(1));
        add_vec("ldi_wait_0",  1, 0, 8'hFF, e_ldi(3'd2, 0));
        add_vec("ldi_wait_1",  1, 0, 8'hFF, e_ldi(3'd2, 0));
        add_vec("ldi_load",    1, 1, 8'hA5, e_ldi(3'd2, 1));
        add_vec("fetch_alu",   1, 1, 8'h8A, e_fetch(1));
        add_vec("exec_alu",    1, 1, 8'hFF, e_alu(3'd1, 3'd2));
        add_vec("fetch_nop",   1, 1, 8'hC5, e_fetch(1));
        add_vec("exec_nop",    1, 1, 8'hFF, e_idle(0));
        add_vec("fetch_halt",  1, 1, 8'hC0, e_fetch(1));
        add_vec("exec_halt",   1, 1, 8'hFF, e_idle(0));
        for (int i = 0; i < 10; i++) begin
            add_vec($sformatf("halted_%0d", i), 1, logic'(i % 2), 8'h0B, e_idle(1));
        end

        $display("[TB] applying %0d table vectors", vecs.size());
        inc_count = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].ready, vecs[i].bus_val,
                          vecs[i].exp, vecs[i].name);
            if (i >= 6 && i <= 9 && bus_if.ADDR_INC === 1'b1) begin
                inc_count++;
            end
        end
        compare("ldi_inc_pulses", inc_count, 2);

        // Reset pulse leaves HALT and restarts fetching.
        applyStimulus(0, 0, 8'hFF, e_idle(0), "halt_reset");
        applyStimulus(1, 0, 8'hFF, e_fetch(0), "halt_restart");

        // Reset asserted asynchronously during an LDI wait.
        applyStimulus(1, 1, 8'h58, e_fetch(1), "fetch_ldi3");
        applyStimulus(1, 0, 8'hFF, e_ldi(3'd3, 0), "ldi3_wait");
        #2;
        RST_bar = 1'b0;
        #1;
        exp_q.push_back(e_idle(0));
        name_q.push_back("async_abort");
        checkOutput();
        compare("ir_cleared", {24'd0, dut.ir_q}, 32'h0000_0000);
        applyStimulus(0, 1, 8'hFF, e_idle(0), "abort_hold");
        applyStimulus(1, 0, 8'hFF, e_fetch(0), "restart_no_load");
        applyStimulus(1, 1, 8'h00, e_fetch(1), "fetch_mov00");
        applyStimulus(1, 1, 8'hFF, e_mov(3'd0, 3'd0), "exec_mov00");
        applyStimulus(1, 0, 8'hFF, e_fetch(0), "back_to_fetch");

        compare("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
